sram_rr_arbiter: RTL and testbench
==================================

Name: sram_rr_arbiter

Overview:
- Shares one single-port, 1-cycle-latency SRAM macro (the team's tc_sram-based memory wrapper) between NumReq requesters, e.g. accelerator core, DMA and system bus.
- Each requester sees an OBI-style req/gnt/rvalid interface.
- Arbitration is round-robin with one grant per cycle.
- The block tracks the outstanding access so each response returns to its owner exactly one cycle after grant.

Parameters:
- NumReq, 2, number of requester ports (1..8).
- NumWords, 1024, SRAM depth in words.
- DataWidth, 32, data width; must be a multiple of 8.
- AddrWidth, derived = (NumWords>1) ? $clog2(NumWords) : 1, word address width; do not override.
- IdxWidth, derived = (NumReq>1) ? $clog2(NumReq) : 1, requester index width; do not override.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NumReq  per-requester access request
- we_i  in  NumReq  per-requester write enable
- addr_i  in  NumReq x AddrWidth  per-requester word address
- wdata_i  in  NumReq x DataWidth  per-requester write data
- be_i  in  NumReq x DataWidth/8  per-requester byte enables
- gnt_o  out  NumReq  grant, one-hot or zero, same cycle as req
- rvalid_o  out  NumReq  response valid, one-hot or zero
- rdata_o  out  DataWidth  read data, shared; qualified by rvalid_o
- mem_req_o  out  1  SRAM request
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  AddrWidth  SRAM address
- mem_wdata_o  out  DataWidth  SRAM write data
- mem_be_o  out  DataWidth/8  SRAM byte enables
- mem_rdata_i  in  DataWidth  SRAM read data, valid one cycle after mem_req_o

Behaviour:
- Reset (async assert, sync deassert by clk_i domain):
  - prio_q=0, rsp_valid_q=0, rsp_idx_q=0, rsp_we_q=0.
  - All outputs are 0 during reset: gnt_o, rvalid_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o.
- Arbitration (combinational):
  - Search req_i starting at index prio_q, ascending, wrapping modulo NumReq.
  - The first asserted index w wins: gnt_o[w]=1 and all other bits are 0.
  - No req_i asserted: gnt_o=0, mem_req_o=0, and mem_we_o/addr/wdata/be are driven 0.
- Memory drive on grant: mem_req_o=1; mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o are copied from requester w in the same cycle. There is no input register, so grant latency is 0.
- Priority update on the clock edge with a grant: prio_q <= (w==NumReq-1) ? 0 : w+1. With no grant, prio_q holds.
- Response tracking, every edge: rsp_valid_q <= (grant this cycle), rsp_idx_q <= w, rsp_we_q <= we_i[w].
- Response output:
  - rvalid_o[rsp_idx_q] = rsp_valid_q; all other bits are 0.
  - Response latency is exactly 1 cycle after gnt, for both reads and writes.
  - rdata_o = mem_rdata_i when rsp_valid_q and !rsp_we_q; otherwise 0, including write responses.
- Back-to-back: a new grant is allowed every cycle, including to the same requester. At most one response is outstanding, so no FIFO is needed.
- Requester contract:
  - A requester holds req/we/addr/wdata/be stable until gnt.
  - A requester may deassert req without gnt. That is legal and produces no access and no response.
- NumReq==1: the port passes through with gnt_o=req_i; prio_q stays 0.
- Reset mid-operation: a pending response is discarded (rvalid_o=0 next cycle) and no memory access is issued during reset.
- Fairness: with all requesters continuously asserting, each is granted once per NumReq cycles, in ascending index order.

Test Plan:
- Reset, then idle -> gnt_o=0, rvalid_o=0, mem_req_o=0, rdata_o=0 for 10 cycles.
- Port0 writes 0xDEADBEEF at addr 0x010 (be=0xF), then the next cycle reads 0x010 -> gnt_o=01 both cycles; rvalid_o=01 at cycles+1 and +2; rdata_o=0 on the write response and 0xDEADBEEF on the read response.
- Both ports request reads continuously for 6 cycles after reset -> grants 0,1,0,1,0,1; rvalid_o follows one cycle late with matching owner; prio_q ends at 0.
- Port1 writes 0x11223344 with be=0x3 over a word containing 0xAAAAAAAA, then port0 reads it -> port0 rdata_o=0xAAAA3344.
- Port1 alone requests on 3 consecutive cycles -> gnt_o=10 every cycle; three rvalid_o[1] pulses with no gaps.
- rst_ni asserted the cycle after port0 is granted a read -> rvalid_o stays 0; after release the first new grant goes to port0 (prio_q=0).

Source files
------------

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency SRAM between NumReq
// OBI-style requesters; one grant per cycle, responses routed back to their owner.
module sram_rr_arbiter #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NumReq-1:0]                      req_i,
    input  logic [NumReq-1:0]                      we_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]       addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]       wdata_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]     be_i,
    output logic [NumReq-1:0]                      gnt_o,
    output logic [NumReq-1:0]                      rvalid_o,
    output logic [DataWidth-1:0]                   rdata_o,
    output logic                                   mem_req_o,
    output logic                                   mem_we_o,
    output logic [AddrWidth-1:0]                   mem_addr_o,
    output logic [DataWidth-1:0]                   mem_wdata_o,
    output logic [DataWidth/8-1:0]                 mem_be_o,
    input  logic [DataWidth-1:0]                   mem_rdata_i
);

    localparam int unsigned BeWidth = DataWidth / 8;
    localparam logic [IdxWidth:0]   NUM_REQ_W = (IdxWidth + 1)'(NumReq);
    localparam logic [IdxWidth-1:0] LAST_IDX  = IdxWidth'(NumReq - 1);

    logic [IdxWidth-1:0] prio_q, prio_d;
    logic [IdxWidth-1:0] rsp_idx_q, rsp_idx_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_we_q, rsp_we_d;

    logic [IdxWidth-1:0] win_s;
    logic [IdxWidth-1:0] cand_s;
    logic [IdxWidth:0]   sum_s;
    logic                found_s;
    logic                grant_s;

    // Round-robin search starting at prio_q, wrapping modulo NumReq
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        sum_s   = '0;
        cand_s  = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            sum_s   = {1'b0, prio_q} + (IdxWidth + 1)'(i);
            sum_s   = (sum_s >= NUM_REQ_W) ? (sum_s - NUM_REQ_W) : sum_s;
            cand_s  = sum_s[IdxWidth-1:0];
            win_s   = (req_i[cand_s] && !found_s) ? cand_s : win_s;
            found_s = found_s | req_i[cand_s];
        end
    end

    // Nothing may reach the SRAM or a requester while reset is asserted
    assign grant_s = found_s & rst_ni;

    // Grant vector and memory-side drive copied from the winning requester
    always_comb begin
        gnt_o       = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (grant_s) begin
            gnt_o[win_s] = 1'b1;
            mem_req_o    = 1'b1;
            mem_we_o     = we_i[win_s];
            mem_addr_o   = addr_i[win_s];
            mem_wdata_o  = wdata_i[win_s];
            mem_be_o     = be_i[win_s][BeWidth-1:0];
        end else begin
            gnt_o     = '0;
            mem_req_o = 1'b0;
        end
    end

    // Next-state: priority rotates past the winner; the single outstanding access is tracked
    always_comb begin
        prio_d      = prio_q;
        rsp_valid_d = grant_s;
        rsp_idx_d   = '0;
        rsp_we_d    = 1'b0;
        if (grant_s) begin
            prio_d    = (win_s == LAST_IDX) ? '0 : (win_s + 1'b1);
            rsp_idx_d = win_s;
            rsp_we_d  = we_i[win_s];
        end else begin
            prio_d = prio_q;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_we_q    <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_we_q    <= rsp_we_d;
        end
    end

    // Response routing; write responses carry zero data
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        if (rsp_valid_q) begin
            rvalid_o[rsp_idx_q] = 1'b1;
            rdata_o             = rsp_we_q ? '0 : mem_rdata_i;
        end else begin
            rvalid_o = '0;
            rdata_o  = '0;
        end
    end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Self-checking bench for sram_rr_arbiter: directed scenarios plus randomized traffic
// checked against a round-robin / memory reference model.
module tb_sram_rr_arbiter;

    localparam int N  = 2;
    localparam int NW = 1024;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_ni;
    logic [N-1:0]            req, we;
    logic [N-1:0][AW-1:0]    addr;
    logic [N-1:0][DW-1:0]    wdata;
    logic [N-1:0][BW-1:0]    be;
    logic [N-1:0]            gnt_o, rvalid_o;
    logic [DW-1:0]           rdata_o;
    logic                    mem_req_o, mem_we_o;
    logic [AW-1:0]           mem_addr_o;
    logic [DW-1:0]           mem_wdata_o;
    logic [BW-1:0]           mem_be_o;
    logic [DW-1:0]           sram_rdata;

    sram_rr_arbiter #(.NumReq(N), .NumWords(NW), .DataWidth(DW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(sram_rdata)
    );

    function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] wd, logic [BW-1:0] b);
        logic [DW-1:0] r;
        r = old;
        for (int k = 0; k < BW; k++) if (b[k]) r[8*k +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    // SRAM macro stand-in: one-cycle read latency, byte-enabled writes
    logic [DW-1:0] sram [NW];
    always @(posedge clk) begin
        if (mem_req_o) begin
            if (mem_we_o) sram[mem_addr_o] <= merge(sram[mem_addr_o], mem_wdata_o, mem_be_o);
            else          sram_rdata <= sram[mem_addr_o];
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [NW];
    int            m_prio;
    bit            m_pend;
    int            m_pidx;
    logic [DW-1:0] m_prdata;
    logic [N-1:0]  m_last_gnt;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] obs_rdata;
    logic [15:0]   gnt_hist;
    logic [15:0]   rv_hist;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prio = 0;
        m_pend = 1'b0;
        m_pidx = 0;
        m_prdata = '0;
        m_last_gnt = '0;
    endtask

    // One clock cycle with inputs already applied; checks outputs at the falling edge
    task automatic step();
        int           w;
        bit           g;
        logic [N-1:0] exp_gnt;
        logic [N-1:0] exp_rv;
        @(negedge clk);
        g = 1'b0;
        w = 0;
        for (int i = 0; i < N; i++) begin
            int c;
            c = (m_prio + i) % N;
            if (!g && req[c]) begin
                g = 1'b1;
                w = c;
            end
        end
        exp_gnt = '0;
        if (g) exp_gnt[w] = 1'b1;
        exp_rv = '0;
        if (m_pend) exp_rv[m_pidx] = 1'b1;
        chk("gnt", gnt_o, exp_gnt);
        chk("mem_req", mem_req_o, g);
        chk("mem_we", mem_we_o, g ? we[w] : 1'b0);
        chk("mem_addr", mem_addr_o, g ? addr[w] : '0);
        chk("mem_wdata", mem_wdata_o, g ? wdata[w] : '0);
        chk("mem_be", mem_be_o, g ? be[w] : '0);
        chk("rvalid", rvalid_o, exp_rv);
        chk("rdata", rdata_o, m_pend ? m_prdata : '0);
        if (m_pend) obs_rdata = rdata_o;
        gnt_hist = {gnt_hist[13:0], gnt_o};
        rv_hist  = {rv_hist[13:0], rvalid_o};
        m_pend = g;
        m_pidx = w;
        m_last_gnt = exp_gnt;
        if (g) begin
            if (we[w]) begin
                ref_mem[addr[w]] = merge(ref_mem[addr[w]], wdata[w], be[w]);
                m_prdata = '0;
            end else begin
                m_prdata = ref_mem[addr[w]];
            end
            m_prio = (w + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    // One cycle under reset: every output must be quiet
    task automatic rst_step();
        @(negedge clk);
        chk("rst_gnt", gnt_o, '0);
        chk("rst_rvalid", rvalid_o, '0);
        chk("rst_rdata", rdata_o, '0);
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_mem_we", mem_we_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, '0);
        chk("rst_mem_wdata", mem_wdata_o, '0);
        chk("rst_mem_be", mem_be_o, '0);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int p, bit r, bit w_en, int a, logic [DW-1:0] d, logic [BW-1:0] b);
        req[p]   = r;
        we[p]    = w_en;
        addr[p]  = AW'(a);
        wdata[p] = d;
        be[p]    = b;
    endtask

    initial begin
        for (int i = 0; i < NW; i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end
        sram_rdata = '0;
        gnt_hist = '0;
        rv_hist  = '0;
        obs_rdata = '0;
        model_reset();

        // Reset with requests pending: nothing may leak out
        rst_ni = 1'b0;
        drive(0, 1'b1, 1'b1, 5, 32'h1234_5678, 4'hF);
        drive(1, 1'b1, 1'b0, 6, 32'h0, 4'hF);
        #1;
        repeat (3) rst_step();
        req = '0;
        rst_ni = 1'b1;
        repeat (10) step();

        // Port0 write then read back
        drive(0, 1'b1, 1'b1, 16'h010, 32'hDEAD_BEEF, 4'hF);
        step();
        drive(0, 1'b1, 1'b0, 16'h010, 32'h0, 4'hF);
        step();
        req = '0;
        step();
        chk("wr_rd_data", obs_rdata, 32'hDEAD_BEEF);
        chk("wr_rd_rvalid", rv_hist[3:0], 4'b01_01);

        // Fairness right after reset: both reading continuously
        rst_ni = 1'b0;
        model_reset();
        rst_step();
        rst_ni = 1'b1;
        drive(0, 1'b1, 1'b0, 16'h010, 32'h0, 4'hF);
        drive(1, 1'b1, 1'b0, 16'h020, 32'h0, 4'hF);
        gnt_hist = '0;
        repeat (6) step();
        chk("fair_seq", gnt_hist[11:0], 12'b01_10_01_10_01_10);
        req = '0;
        step();
        chk("fair_last_rv", rv_hist[1:0], 2'b10);

        // Partial write by port1 over a known word, read back by port0
        drive(1, 1'b1, 1'b1, 16'h030, 32'hAAAA_AAAA, 4'hF);
        step();
        drive(1, 1'b1, 1'b1, 16'h030, 32'h1122_3344, 4'h3);
        step();
        req[1] = 1'b0;
        drive(0, 1'b1, 1'b0, 16'h030, 32'h0, 4'hF);
        step();
        req = '0;
        step();
        chk("partial_wr", obs_rdata, 32'hAAAA_3344);

        // Port1 alone, back-to-back
        drive(1, 1'b1, 1'b0, 16'h030, 32'h0, 4'hF);
        gnt_hist = '0;
        rv_hist  = '0;
        repeat (3) step();
        req = '0;
        step();
        chk("b2b_gnt", gnt_hist[7:0], 8'b10_10_10_00);
        chk("b2b_rv", rv_hist[7:0], 8'b00_10_10_10);

        // Reset right after a port0 read grant: response dropped, priority restarts at 0
        drive(0, 1'b1, 1'b0, 16'h010, 32'h0, 4'hF);
        step();
        rst_ni = 1'b0;
        model_reset();
        drive(1, 1'b1, 1'b0, 16'h020, 32'h0, 4'hF);
        rst_step();
        rst_ni = 1'b1;
        gnt_hist = '0;
        step();
        chk("post_rst_gnt", gnt_hist[1:0], 2'b01);
        req = '0;
        step();

        // Randomized traffic obeying the hold-until-grant contract
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < N; p++) begin
                if (req[p] && !m_last_gnt[p]) begin
                    if ($urandom_range(7) == 0) req[p] = 1'b0;
                end else begin
                    drive(p, 1'($urandom_range(1)), 1'($urandom_range(1)),
                          int'($urandom_range(15)), $urandom, BW'($urandom_range(15)));
                end
            end
            step();
        end
        req = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
